// File: rtl/wordle_pkg.sv
// Shared Wordle datapath constants: cell/row geometry, letter codes and the
// guess_entry controller state encoding.
package wordle_pkg;

  localparam int CELL_W   = 7;
  localparam int LETTER_W = 5;
  localparam int WORD_LEN = 5;
  localparam int ROW_W    = CELL_W * WORD_LEN;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd0;
  localparam logic [LETTER_W-1:0] LETTER_A     = 5'd1;
  localparam logic [LETTER_W-1:0] LETTER_Z     = 5'd26;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    EVAL  = 2'd1,
    WON   = 2'd2,
    LOST  = 2'd3
  } state_e;

endpackage

// File: rtl/guess_entry.sv
// Guess-entry and board controller: builds the active row from keystrokes,
// hands it to the colour evaluator and stores the coloured result.
//
// state | meaning
// ENTRY | collecting letters / delete / submit for row row_idx
// EVAL  | one cycle: evaluator result written into row row_idx
// WON   | terminal, last guess fully green
// LOST  | terminal, final row used without a win
module guess_entry
  import wordle_pkg::*;
#(
  parameter int ROWS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [LETTER_W-1:0]   key_code,
  input  logic                  key_del,
  input  logic                  key_enter,
  input  logic                  new_game,
  output logic [ROW_W-1:0]      eval_row,
  input  logic [ROW_W-1:0]      eval_result,
  input  logic                  eval_done,
  output logic [ROWS*ROW_W-1:0] board,
  output logic [2:0]            row_idx,
  output logic [2:0]            col_idx,
  output logic                  busy,
  output logic                  game_won,
  output logic                  game_lost
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] FULL_COL = 3'(WORD_LEN);

  state_e                        state_q, state_d;
  logic [ROWS-1:0][ROW_W-1:0]    board_q, board_d;
  logic [2:0]                    row_q, row_d;
  logic [2:0]                    col_q, col_d;
  logic                          busy_q, busy_d;
  logic                          won_q, won_d;
  logic                          lost_q, lost_d;

  logic [ROW_W-1:0]              cur_row;
  logic [ROW_W-1:0]              new_row;
  logic                          write_row;
  logic                          letter_ok;

  always_comb begin
    cur_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == 3'(r)) cur_row = board_q[r];
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = 1'b0;
    won_d     = won_q;
    lost_d    = lost_q;
    new_row   = cur_row;
    write_row = 1'b0;
    letter_ok = (key_code >= LETTER_A) && (key_code <= LETTER_Z);

    case (state_q)
      ENTRY: begin
        // A present enter strobe claims the cycle even when it is ignored.
        if (key_enter) begin
          if (col_q == FULL_COL) begin
            state_d = EVAL;
            busy_d  = 1'b1;
          end
        end else if (key_del) begin
          if (col_q != 3'd0) begin
            for (int c = 0; c < WORD_LEN; c++) begin
              if (3'(c) == FULL_COL - col_q) new_row[c*CELL_W +: CELL_W] = '0;
            end
            write_row = 1'b1;
            col_d     = col_q - 3'd1;
          end
        end else if (key_valid) begin
          if (letter_ok && (col_q < FULL_COL)) begin
            for (int c = 0; c < WORD_LEN; c++) begin
              if (3'(c) == 3'd4 - col_q) new_row[c*CELL_W +: CELL_W] = {2'b00, key_code};
            end
            write_row = 1'b1;
            col_d     = col_q + 3'd1;
          end
        end
      end
      EVAL: begin
        new_row   = eval_result;
        write_row = 1'b1;
        if (eval_done) begin
          state_d = WON;
          won_d   = 1'b1;
        end else if (row_q == LAST_ROW) begin
          state_d = LOST;
          lost_d  = 1'b1;
        end else begin
          state_d = ENTRY;
          row_d   = row_q + 3'd1;
          col_d   = 3'd0;
        end
      end
      default: ;
    endcase

    if (write_row) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == 3'(r)) board_d[r] = new_row;
      end
    end

    // Restart discards anything in flight, including an EVAL write.
    if (new_game) begin
      state_d = ENTRY;
      board_d = '0;
      row_d   = 3'd0;
      col_d   = 3'd0;
      busy_d  = 1'b0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      board_q <= '0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      busy_q  <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
    end
  end

  assign eval_row  = cur_row;
  assign board     = board_q;
  assign row_idx   = row_q;
  assign col_idx   = col_q;
  assign busy      = busy_q;
  assign game_won  = won_q;
  assign game_lost = lost_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with a behavioural colour evaluator for the
// chosen word CRANE; expectations are queued at drive time and popped on check.
module tb_guess_entry;
  import wordle_pkg::*;

  localparam int R = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_valid;
  logic [4:0]       key_code;
  logic             key_del;
  logic             key_enter;
  logic             new_game;
  logic [34:0]      eval_row;
  logic [34:0]      eval_result;
  logic             eval_done;
  logic [R*35-1:0]  board;
  logic [2:0]       row_idx;
  logic [2:0]       col_idx;
  logic             busy;
  logic             game_won;
  logic             game_lost;

  guess_entry #(.ROWS(R)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_code(key_code), .key_del(key_del),
    .key_enter(key_enter), .new_game(new_game),
    .eval_row(eval_row), .eval_result(eval_result), .eval_done(eval_done),
    .board(board), .row_idx(row_idx), .col_idx(col_idx), .busy(busy),
    .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  // Evaluator stand-in: word CRANE, first letter in the top cell.
  logic [24:0] chosen = {5'd3, 5'd18, 5'd1, 5'd14, 5'd5};
  always_comb begin
    logic [4:0] g;
    logic       grn;
    logic       yel;
    eval_result = '0;
    eval_done   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      g   = eval_row[7*c +: 5];
      grn = (g == chosen[5*c +: 5]);
      yel = 1'b0;
      for (int k = 0; k < 5; k++)
        if (k != c && g == chosen[5*k +: 5]) yel = 1'b1;
      if (grn) yel = 1'b0;
      eval_result[7*c +: 7] = {yel, grn, g};
      if (!grn) eval_done = 1'b0;
    end
  end

  logic [255:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [34:0] word_row(input logic [24:0] w);
    logic [34:0] r;
    for (int c = 0; c < 5; c++) r[7*c +: 7] = {2'b00, w[5*c +: 5]};
    return r;
  endfunction

  task automatic expect_v(input logic [255:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs);
    logic [255:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  // Drive one cycle of strobes at the negedge, sample at the following negedge.
  task automatic step(input logic kv, input logic [4:0] kc, input logic kd,
                      input logic ke, input logic ng);
    key_valid = kv; key_code = kc; key_del = kd; key_enter = ke; new_game = ng;
    @(posedge clk);
    #1;
    key_valid = 0; key_code = 0; key_del = 0; key_enter = 0; new_game = 0;
    @(negedge clk);
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) step(1'b1, w[24-5*i -: 5], 1'b0, 1'b0, 1'b0);
  endtask

  logic [24:0] w_crane = {5'd3, 5'd18, 5'd1, 5'd14, 5'd5};
  logic [24:0] w_nacre = {5'd14, 5'd1, 5'd3, 5'd18, 5'd5};
  logic [24:0] w_bumpy = {5'd2, 5'd21, 5'd13, 5'd16, 5'd25};
  logic [34:0] crane_col, nacre_col, bumpy_row;
  logic [R*35-1:0] exp_board;

  initial begin
    rst = 1; key_valid = 0; key_code = 0; key_del = 0; key_enter = 0; new_game = 0;
    crane_col = {7'b0100011, 7'b0110010, 7'b0100001, 7'b0101110, 7'b0100101};
    nacre_col = {7'b1001110, 7'b1000001, 7'b1000011, 7'b1010010, 7'b0100101};
    bumpy_row = word_row(w_bumpy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    expect_v(256'(0)); chk("reset_board", 256'(board));
    expect_v(256'(0)); chk("reset_flags", 256'({row_idx, col_idx, busy, game_won, game_lost}));
    expect_v(256'(0)); chk("reset_eval_row", 256'(eval_row));

    step(1, 5'd3, 0, 0, 0);
    step(1, 5'd18, 0, 0, 0);
    step(1, 5'd0, 0, 0, 0);
    step(1, 5'd1, 0, 0, 0);
    expect_v(256'(3)); chk("cra_col", 256'(col_idx));
    expect_v(256'({7'd3, 7'd18, 7'd1, 14'd0})); chk("cra_row0", 256'(board[34:0]));
    expect_v(256'({7'd3, 7'd18, 7'd1, 14'd0})); chk("cra_eval_row", 256'(eval_row));

    step(0, 0, 1, 0, 0);
    expect_v(256'({7'd3, 7'd18, 21'd0})); chk("del1_row0", 256'(board[34:0]));
    repeat (3) step(0, 0, 1, 0, 0);
    expect_v(256'(0)); chk("del4_col", 256'(col_idx));
    expect_v(256'(0)); chk("del4_board", 256'(board));

    type_word(w_crane);
    step(0, 0, 0, 1, 0);
    expect_v(256'(1)); chk("mid_eval_busy", 256'(busy));
    step(0, 0, 0, 0, 1);
    expect_v(256'(0)); chk("newgame_board", 256'(board));
    expect_v(256'(0)); chk("newgame_flags", 256'({row_idx, col_idx, busy, game_won, game_lost}));
    step(0, 0, 0, 0, 0);
    expect_v(256'(0)); chk("newgame_settled", 256'({board, busy, game_won}));

    for (int i = 0; i < 4; i++) step(1, w_crane[24-5*i -: 5], 0, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_v(256'({3'd4, 1'b0})); chk("short_enter", 256'({col_idx, busy}));
    step(1, 5'd5, 0, 0, 0);
    expect_v(256'(word_row(w_crane))); chk("crane_typed", 256'(board[34:0]));
    step(1, 5'd7, 0, 1, 0);
    expect_v(256'({3'd5, 1'b1})); chk("enter_wins", 256'({col_idx, busy}));
    expect_v(256'(word_row(w_crane))); chk("enter_wins_row", 256'(board[34:0]));
    step(0, 0, 0, 0, 0);
    expect_v(256'({1'b1, 1'b0, 1'b0, 3'd0})); chk("crane_flags", 256'({game_won, game_lost, busy, row_idx}));
    expect_v(256'(crane_col)); chk("crane_colours", 256'(board[34:0]));
    step(1, 5'd9, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_v(256'({crane_col, 1'b0})); chk("won_frozen", 256'({board[34:0], busy}));

    step(0, 0, 0, 0, 1);
    type_word(w_nacre);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    expect_v(256'(nacre_col)); chk("nacre_colours", 256'(board[34:0]));
    expect_v(256'({3'd1, 3'd0, 1'b0, 1'b0})); chk("nacre_progress", 256'({row_idx, col_idx, game_won, game_lost}));
    expect_v(256'(0)); chk("nacre_eval_row", 256'(eval_row));

    for (int g = 1; g < 6; g++) begin
      type_word(w_bumpy);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      expect_v(256'({(g < 5) ? 3'(g + 1) : 3'd5, g == 5, 1'b0}));
      chk($sformatf("guess%0d_progress", g + 1), 256'({row_idx, game_lost, game_won}));
    end
    exp_board = '0;
    exp_board[34:0] = nacre_col;
    for (int r = 1; r < R; r++) exp_board[35*r +: 35] = bumpy_row;
    expect_v(256'(exp_board)); chk("lost_board", 256'(board));
    step(1, 5'd3, 0, 0, 0);
    expect_v(256'(exp_board)); chk("lost_key_board", 256'(board));
    expect_v(256'({1'b1, 3'd5, 1'b0})); chk("lost_key_flags", 256'({game_lost, row_idx, busy}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
